// File: rtl/ie_branch_unit_if.sv
// Request, memory-read and result signals of the IE branch/jump resolver.
// The master side is the IE stage plus memory; the slave side is the branch unit.
interface ie_branch_unit_if #(
    parameter int unsigned PC_W = 16
);
    logic            start;
    logic [7:0]      op;
    logic            jmp_ind;
    logic [PC_W-1:0] operand;
    logic [PC_W-1:0] pc_in;
    logic [7:0]      status;

    logic            mem_rd;
    logic [PC_W-1:0] mem_addr;
    logic [7:0]      mem_data;
    logic            mem_valid;

    logic            busy;
    logic            done;
    logic [PC_W-1:0] pc_out;
    logic            taken;
    logic [1:0]      extra_cycles;
    logic            illegal;

    modport master (
        output start, op, jmp_ind, operand, pc_in, status, mem_data, mem_valid,
        input  mem_rd, mem_addr, busy, done, pc_out, taken, extra_cycles, illegal
    );

    modport slave (
        input  start, op, jmp_ind, operand, pc_in, status, mem_data, mem_valid,
        output mem_rd, mem_addr, busy, done, pc_out, taken, extra_cycles, illegal
    );
endinterface

// File: rtl/ie_branch_unit.sv
// IE-stage branch/jump resolver: evaluates 6502 branch conditions, computes the
// next PC with page-cross penalty, and fetches indirect JMP vectors.
module ie_branch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic             clk_i,
    input logic             rst_ni,
    ie_branch_unit_if.slave bus_io
);
    localparam logic [7:0] OpBcc = 8'h04;
    localparam logic [7:0] OpBcs = 8'h05;
    localparam logic [7:0] OpBeq = 8'h06;
    localparam logic [7:0] OpBmi = 8'h07;
    localparam logic [7:0] OpBne = 8'h08;
    localparam logic [7:0] OpBpl = 8'h09;
    localparam logic [7:0] OpBvc = 8'h0A;
    localparam logic [7:0] OpBvs = 8'h0B;
    localparam logic [7:0] OpJmp = 8'h1C;

    typedef enum logic [2:0] {StIdle, StExec, StPage, StIndLo, StIndHi, StDone} state_e;

    state_e          state_q;
    logic [7:0]      op_q;
    logic            jmp_ind_q;
    logic [PC_W-1:0] opnd_q;     // offset / target / pointer; reused for page-cross target
    logic [PC_W-1:0] pc_q;
    logic [3:0]      flags_q;    // {N, V, Z, C}
    logic [7:0]      lo_q;
    logic            mem_rd_q;
    logic [PC_W-1:0] mem_addr_q;
    logic            busy_q;
    logic            done_q;
    logic [PC_W-1:0] pc_out_q;
    logic            taken_q;
    logic [1:0]      extra_q;
    logic            illegal_q;

    logic            is_branch;
    logic            cond_met;
    logic [PC_W-1:0] branch_tgt;
    logic            same_page;
    logic [PC_W-1:0] ind_hi_addr;

    // Decode the latched op and evaluate its condition against the latched flags.
    always_comb begin
        is_branch = 1'b1;
        cond_met  = 1'b0;
        case (op_q)
            OpBcc:   cond_met = ~flags_q[0];
            OpBcs:   cond_met =  flags_q[0];
            OpBeq:   cond_met =  flags_q[1];
            OpBne:   cond_met = ~flags_q[1];
            OpBmi:   cond_met =  flags_q[3];
            OpBpl:   cond_met = ~flags_q[3];
            OpBvc:   cond_met = ~flags_q[2];
            OpBvs:   cond_met =  flags_q[2];
            default: is_branch = 1'b0;
        endcase
    end

    assign branch_tgt  = pc_q + {{(PC_W-8){opnd_q[7]}}, opnd_q[7:0]};
    assign same_page   = branch_tgt[PC_W-1:8] == pc_q[PC_W-1:8];
    // High byte deliberately does not carry (6502 indirect JMP page-wrap).
    assign ind_hi_addr = {opnd_q[PC_W-1:8], opnd_q[7:0] + 8'd1};

    // Control FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            op_q       <= '0;
            jmp_ind_q  <= 1'b0;
            opnd_q     <= '0;
            pc_q       <= '0;
            flags_q    <= '0;
            lo_q       <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_out_q   <= RESET_PC;
            taken_q    <= 1'b0;
            extra_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        op_q      <= bus_io.op;
                        jmp_ind_q <= bus_io.jmp_ind;
                        opnd_q    <= bus_io.operand;
                        pc_q      <= bus_io.pc_in;
                        flags_q   <= {bus_io.status[7], bus_io.status[6],
                                      bus_io.status[1], bus_io.status[0]};
                        busy_q    <= 1'b1;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    if (op_q == OpJmp) begin
                        if (jmp_ind_q) begin
                            mem_addr_q <= opnd_q;
                            mem_rd_q   <= 1'b1;
                            state_q    <= StIndLo;
                        end else begin
                            pc_out_q <= opnd_q;
                            taken_q  <= 1'b1;
                            extra_q  <= 2'd0;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end else if (is_branch && cond_met) begin
                        if (same_page) begin
                            pc_out_q <= branch_tgt;
                            taken_q  <= 1'b1;
                            extra_q  <= 2'd1;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            // Results are published with done, after the penalty cycle.
                            opnd_q  <= branch_tgt;
                            state_q <= StPage;
                        end
                    end else begin
                        pc_out_q  <= pc_q;
                        taken_q   <= 1'b0;
                        extra_q   <= 2'd0;
                        illegal_q <= ~is_branch;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StPage: begin
                    pc_out_q <= opnd_q;
                    taken_q  <= 1'b1;
                    extra_q  <= 2'd2;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StIndLo: begin
                    if (bus_io.mem_valid) begin
                        lo_q       <= bus_io.mem_data;
                        mem_addr_q <= ind_hi_addr;
                        state_q    <= StIndHi;
                    end
                end
                StIndHi: begin
                    if (bus_io.mem_valid) begin
                        mem_rd_q <= 1'b0;
                        pc_out_q <= {bus_io.mem_data, lo_q};
                        taken_q  <= 1'b1;
                        extra_q  <= 2'd0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    illegal_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.mem_rd       = mem_rd_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.done         = done_q;
    assign bus_io.pc_out       = pc_out_q;
    assign bus_io.taken        = taken_q;
    assign bus_io.extra_cycles = extra_q;
    assign bus_io.illegal      = illegal_q;
endmodule

// File: tb/tb_ie_branch_unit.sv
// Scoreboard bench for ie_branch_unit: a driver pushes model results, a monitor
// pops and compares on every done pulse, and a memory responder serves reads.
module tb_ie_branch_unit;
    localparam logic [15:0] RstPc = 16'hFFFC;

    typedef struct {
        logic [15:0] pc;
        logic        taken;
        logic [1:0]  extra;
        logic        ill;
        int          lat;
        int          c0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    ie_branch_unit_if #(.PC_W(16)) bus_if ();

    ie_branch_unit #(
        .PC_W    (16),
        .RESET_PC(RstPc)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus_io(bus_if)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_wait = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log[$];
    exp_t        sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: 6502 branch/JMP rules in plain integer arithmetic.
    function automatic exp_t model(input logic [7:0] op, input logic ind,
                                   input logic [15:0] opnd, input logic [15:0] pc,
                                   input logic [7:0] st, input int w);
        exp_t e;
        int   off, tgt, p, p2;
        bit   is_br, cond;
        e.pc = pc; e.taken = 1'b0; e.extra = 2'd0; e.ill = 1'b0; e.lat = 2; e.c0 = 0;
        is_br = 1'b1;
        cond  = 1'b0;
        case (op)
            8'h04: cond = (st[0] == 1'b0);
            8'h05: cond = (st[0] == 1'b1);
            8'h06: cond = (st[1] == 1'b1);
            8'h07: cond = (st[7] == 1'b1);
            8'h08: cond = (st[1] == 1'b0);
            8'h09: cond = (st[7] == 1'b0);
            8'h0A: cond = (st[6] == 1'b0);
            8'h0B: cond = (st[6] == 1'b1);
            default: is_br = 1'b0;
        endcase
        if (op == 8'h1C) begin
            e.taken = 1'b1;
            if (ind) begin
                p   = int'(opnd);
                p2  = (p / 256) * 256 + ((p % 256) + 1) % 256;
                tgt = int'(mem[p]) + 256 * int'(mem[p2]);
                e.lat = 4 + 2 * w;
            end else begin
                tgt = int'(opnd);
            end
            e.pc = 16'(tgt);
        end else if (is_br) begin
            if (cond) begin
                off = int'(opnd[7:0]);
                if (off > 127) off -= 256;
                tgt = (int'(pc) + off + 65536) % 65536;
                e.pc = 16'(tgt);
                e.taken = 1'b1;
                if (tgt / 256 != int'(pc) / 256) begin
                    e.extra = 2'd2;
                    e.lat = 3;
                end else begin
                    e.extra = 2'd1;
                end
            end
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni === 1'b1 && bus_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: got done=1, expected no pending request");
            end else begin
                e = sb.pop_front();
                chk("pc_out", 32'(bus_if.pc_out), 32'(e.pc));
                chk("taken", 32'(bus_if.taken), 32'(e.taken));
                chk("extra_cycles", 32'(bus_if.extra_cycles), 32'(e.extra));
                chk("illegal", 32'(bus_if.illegal), 32'(e.ill));
                chk("latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
            end
        end
    end

    // Memory responder with programmable wait; random mem_valid noise while idle.
    logic        prev_rd = 1'b0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_addr = '0;
    int          wcnt = 0;
    always @(negedge clk) begin
        if (bus_if.mem_rd === 1'b1 && prev_rd && !prev_valid)
            chk("mem_addr_stable", 32'(bus_if.mem_addr), 32'(prev_addr));
        prev_rd   = bus_if.mem_rd;
        prev_addr = bus_if.mem_addr;
        if (bus_if.mem_rd !== 1'b1) begin
            wcnt = 0;
            bus_if.mem_valid = 1'($urandom_range(0, 1));
            bus_if.mem_data  = 8'($urandom);
        end else begin
            if (bus_if.mem_valid) begin
                bus_if.mem_valid = 1'b0;
                wcnt = 0;
            end
            if (wcnt >= mem_wait) begin
                bus_if.mem_valid = 1'b1;
                bus_if.mem_data  = mem[bus_if.mem_addr];
                rd_log.push_back(bus_if.mem_addr);
            end else begin
                wcnt++;
            end
        end
        prev_valid = bus_if.mem_valid;
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.busy === 1'b0 && sb.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d, expected idle", bus_if.busy,
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic ind, input logic [15:0] opnd,
                         input logic [15:0] pc, input logic [7:0] st, input int w);
        exp_t e;
        wait_idle();
        mem_wait = w;
        @(negedge clk);
        bus_if.op = op; bus_if.jmp_ind = ind; bus_if.operand = opnd;
        bus_if.pc_in = pc; bus_if.status = st; bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        e = model(op, ind, opnd, pc, st, w);
        e.c0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        // Scramble the live inputs; the unit must work from its latched copies.
        bus_if.start = 1'b0;
        bus_if.op = 8'($urandom); bus_if.jmp_ind = 1'($urandom);
        bus_if.operand = 16'($urandom); bus_if.pc_in = 16'($urandom);
        bus_if.status = 8'($urandom);
    endtask

    logic [7:0] br_ops [8] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    int         br_bit [8] = '{0, 0, 1, 7, 1, 7, 6, 6};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        bit         ok;
        int         k;
        rst_ni = 1'b0;
        bus_if.start = 1'b0; bus_if.op = '0; bus_if.jmp_ind = 1'b0;
        bus_if.operand = '0; bus_if.pc_in = '0; bus_if.status = '0;
        bus_if.mem_valid = 1'b0; bus_if.mem_data = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_mem_rd", 32'(bus_if.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_pc_out", 32'(bus_if.pc_out), 32'(RstPc));
        chk("rst_taken", 32'(bus_if.taken), 32'd0);
        chk("rst_extra", 32'(bus_if.extra_cycles), 32'd0);
        chk("rst_illegal", 32'(bus_if.illegal), 32'd0);
        rst_ni = 1'b1;

        // Directed cases.
        issue(8'h06, 1'b0, 16'h0020, 16'h80F0, 8'h02, 0);    // BEQ page cross
        issue(8'h04, 1'b0, 16'h00FE, 16'h8005, 8'h00, 0);    // BCC same page
        issue(8'h04, 1'b0, 16'h00FE, 16'h8005, 8'h01, 0);    // BCC not taken
        issue(8'h06, 1'b0, 16'h007F, 16'hFFF0, 8'h02, 0);    // wrap to 0x006F
        for (int i = 0; i < 8; i++) begin
            st = 8'(1 << br_bit[i]);
            issue(br_ops[i], 1'b0, 16'($urandom), 16'($urandom), st, 0);
            issue(br_ops[i], 1'b0, 16'($urandom), 16'($urandom), ~st, 0);
        end

        // Indirect JMP with page-wrapped pointer and 3 wait cycles per read.
        mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12; mem[16'h0300] = 8'hEE;
        wait_idle();
        rd_log.delete();
        issue(8'h1C, 1'b1, 16'h02FF, 16'h4000, 8'h00, 3);
        wait_idle();
        chk("ind_read_count", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) begin
            chk("ind_read_addr0", 32'(rd_log[0]), 32'h02FF);
            chk("ind_read_addr1", 32'(rd_log[1]), 32'h0200);
        end

        issue(8'h00, 1'b0, 16'h1234, 16'h5678, 8'hFF, 0);    // illegal

        // A second start while busy must be ignored (monitor flags any extra done).
        issue(8'h1C, 1'b0, 16'hBEEF, 16'h1000, 8'h00, 0);
        bus_if.op = 8'h1C; bus_if.jmp_ind = 1'b0; bus_if.operand = 16'h0BAD;
        bus_if.start = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.start = 1'b0;

        // Reset while waiting for the high vector byte.
        mem[16'h0340] = 8'h55; mem[16'h0341] = 8'h66;
        issue(8'h1C, 1'b1, 16'h0340, 16'h2000, 8'h00, 5);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.mem_rd === 1'b1 && bus_if.mem_addr === 16'h0341) ok = 1'b1;
        end
        chk("reach_ind_hi", 32'(ok), 32'd1);
        @(negedge clk);
        sb.delete();
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_mem_rd", 32'(bus_if.mem_rd), 32'd0);
        chk("midrst_busy", 32'(bus_if.busy), 32'd0);
        chk("midrst_done", 32'(bus_if.done), 32'd0);
        chk("midrst_pc_out", 32'(bus_if.pc_out), 32'(RstPc));
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        issue(8'h1C, 1'b0, 16'hC000, 16'h2000, 8'h00, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 10);
            if (k < 8)
                issue(br_ops[k], 1'b0, 16'($urandom), 16'($urandom), 8'($urandom), 0);
            else if (k == 8)
                issue(8'h1C, 1'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                      $urandom_range(0, 2));
            else
                issue(8'(8'h10 + $urandom_range(0, 11)), 1'b0, 16'($urandom),
                      16'($urandom), 8'($urandom), 0);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ie_branch_unit.md
Name: ie_branch_unit

Overview:
- Branch/jump resolver inside the CPU instruction-execute (IE) stage.
- Consumes the IE branch codes BCC=0x04, BCS=0x05, BEQ=0x06, BMI=0x07, BNE=0x08, BPL=0x09, BVC=0x0A, BVS=0x0B and JMP=0x1C.
- Evaluates the branch condition against the 6502 status register and computes the next PC, including the 6502 page-cross penalty.
- For indirect JMP, fetches the target vector over the IE memory read handshake.

Parameters:
- PC_W, 16, PC/address width.
- RESET_PC, 16'h0000, pc_out value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled in IDLE only.
- op  in  8  IE branch code.
- jmp_ind  in  1  JMP only: 1 = indirect, 0 = absolute.
- operand  in  16  branch: [7:0] signed offset; JMP abs: target; JMP ind: pointer.
- pc_in  in  16  address of the next sequential instruction.
- status  in  8  P register: N=bit7, V=bit6, Z=bit1, C=bit0.
- mem_rd  out  1  read request; held high until mem_valid.
- mem_addr  out  16  read address; stable while mem_rd is high.
- mem_data  in  8  read data; valid when mem_valid is high.
- mem_valid  in  1  read complete; data is captured on this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- pc_out  out  16  resolved next PC; held until the next done.
- taken  out  1  branch/jump taken; held with pc_out.
- extra_cycles  out  2  penalty: 0 = not taken, 1 = taken same page, 2 = taken page cross; 0 for JMP.
- illegal  out  1  pulses with done when op is not a branch code.

Behaviour:
- Reset values (asynchronous, rst=0): state=IDLE, mem_rd=0, mem_addr=0, busy=0, done=0, pc_out=RESET_PC, taken=0, extra_cycles=0, illegal=0. All outputs are registered.
- States: IDLE, EXEC, PAGE, IND_LO, IND_HI, DONE.
- IDLE:
  - On start=1, latch op, jmp_ind, operand, pc_in and status, then go to EXEC.
  - start is ignored in every other state; there is no queueing.
- EXEC, condition evaluation:
  - BCC: C=0. BCS: C=1.
  - BEQ: Z=1. BNE: Z=0.
  - BMI: N=1. BPL: N=0.
  - BVC: V=0. BVS: V=1.
- EXEC, branch not taken: pc_out=pc_in, taken=0, extra=0, go to DONE.
- EXEC, branch taken:
  - target = pc_in + sign-extended offset, computed modulo 2^16 (0xFFFF+1 wraps to 0x0000).
  - If target[15:8] == pc_in[15:8]: extra=1, go to DONE.
  - Otherwise: extra=2, go to PAGE.
- EXEC, JMP absolute: pc_out=operand, taken=1, extra=0, go to DONE.
- EXEC, JMP indirect: mem_addr=operand, mem_rd=1, go to IND_LO.
- EXEC, any other op: pc_out=pc_in, taken=0, extra=0, illegal=1, go to DONE.
- PAGE: one idle cycle that models the page-cross penalty, then go to DONE.
- IND_LO:
  - Wait for mem_valid; a wait of any length is allowed.
  - On mem_valid: capture lo=mem_data.
  - Set mem_addr={ptr[15:8], ptr[7:0]+1}. This reproduces the 6502 page-wrap bug: the high byte never carries.
  - Keep mem_rd high and go to IND_HI.
- IND_HI: on mem_valid, drop mem_rd, set pc_out={mem_data, lo}, taken=1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE; illegal clears with done.
- Latency, start sampled at edge 0 and zero-wait memory:
  - done high in cycle 2 for not-taken, same-page, JMP absolute and illegal.
  - done high in cycle 3 for page cross.
  - done high in cycle 4 for JMP indirect, plus 1 cycle per memory wait cycle.
- mem_valid while mem_rd=0 is ignored.
- Reset asserted mid-operation: immediate return to IDLE; mem_rd drops asynchronously; no done is produced; pc_out=RESET_PC.
- Inputs other than mem_* may change after start is sampled; the latched copies are used.

Test Plan:
- BEQ, Z=1, pc_in=0x80F0, offset=0x20 -> pc_out=0x8110, taken=1, extra=2, done in cycle 3.
- BCC, C=0, pc_in=0x8005, offset=0xFE -> pc_out=0x8003, extra=1, done in cycle 2. BCC with C=1 -> pc_out=0x8005, taken=0, extra=0.
- All 8 conditional ops, each with its flag set and clear -> taken matches the condition table; pc_in=0xFFF0, offset=0x7F -> pc_out=0x006F, extra=2.
- JMP indirect, ptr=0x02FF, mem[0x02FF]=0x34, mem[0x0200]=0x12, 3 wait cycles per read -> read addresses are 0x02FF then 0x0200; pc_out=0x1234; mem_addr stable while mem_rd is high.
- op=0x00 -> illegal=1 with done, pc_out=pc_in. A second start while busy -> ignored.
- rst low during IND_HI -> mem_rd=0 and busy=0 immediately, no done pulse; a fresh JMP absolute to 0xC000 afterwards -> pc_out=0xC000.
